// File: rtl/irq_controller_if.sv
// Peripheral interrupt lines, config bus and CP0 request/ack/eret handshake of irq_controller.
// slave = the controller side, master = the environment (peripherals, EXE stage, CP0).
interface irq_controller_if #(
  parameter int N_SRC = 8
);
  logic [N_SRC-1:0] irq_src;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic [31:0]      cfg_rdata;
  logic             ir_out;
  logic             ir_ack;
  logic             eret;
  logic [4:0]       irq_id;
  logic             busy;

  modport master (
    output irq_src, cfg_we, cfg_addr, cfg_wdata, ir_ack, eret,
    input  cfg_rdata, ir_out, irq_id, busy
  );

  modport slave (
    input  irq_src, cfg_we, cfg_addr, cfg_wdata, ir_ack, eret,
    output cfg_rdata, ir_out, irq_id, busy
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt front-end for CP0: qualify, mask and fixed-priority pick one of N_SRC lines; optional IRQ_SYNC_EN adds a 2-flop input synchroniser.
// Rise -> ir_out in 2 posedges (4 with IRQ_SYNC_EN); cfg reads 1 cycle; a raised ir_out holds until ir_ack, no nesting.
module irq_controller #(
  parameter int N_SRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  irq_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] A_MASK  = 2'd0;
  localparam logic [1:0] A_PEND  = 2'd1;
  localparam logic [1:0] A_CAUSE = 2'd2;
  localparam logic [1:0] A_EDGE  = 2'd3;

  logic [N_SRC-1:0] src_s;
  logic [N_SRC-1:0] src_d_q, src_d_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_q, edge_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] cfg_clr;
  logic [1:0]       state_q, state_d;
  logic [4:0]       irq_id_q, irq_id_d;
  logic [4:0]       win_id;
  logic             ir_out_q, ir_out_d;
  logic             busy_q, busy_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      rdata_q, rdata_d;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync1_d;
  logic [N_SRC-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.irq_src;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = bus.irq_src;
`endif

  always_comb begin
    src_d_d  = src_s;
    rise     = src_s & ~src_d_q;
    eligible = pend_q & mask_q;
  end

  // Downward scan so the lowest set index is the last one written.
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 5'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ir_out_d = ir_out_q;
    busy_d   = busy_q;
    cause_d  = cause_q;
    ack_clr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d  = ST_REQ;
          irq_id_d = win_id;
          ir_out_d = 1'b1;
          busy_d   = 1'b1;
          cause_d  = {1'b1, 26'd0, win_id};
        end
      end
      // CP0 latches ir_in, so REQ ignores MASK/PENDING changes until ir_ack.
      ST_REQ: begin
        if (bus.ir_ack) begin
          state_d  = ST_SERVICE;
          ir_out_d = 1'b0;
          for (int i = 0; i < N_SRC; i++) begin
            if (irq_id_q == 5'(i)) ack_clr[i] = 1'b1;
          end
        end
      end
      ST_SERVICE: begin
        if (bus.eret) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cause_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ir_out_d = 1'b0;
        busy_d   = 1'b0;
        cause_d  = '0;
      end
    endcase
  end

  always_comb begin
    cfg_clr = '0;
    mask_d  = mask_q;
    edge_d  = edge_q;
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        A_MASK:  mask_d  = bus.cfg_wdata[N_SRC-1:0];
        A_PEND:  cfg_clr = bus.cfg_wdata[N_SRC-1:0];
        A_EDGE:  edge_d  = bus.cfg_wdata[N_SRC-1:0];
        default: ;
      endcase
    end
  end

  // Edge sources: sticky, a new rise beats a same-cycle clear. Level sources follow the line.
  always_comb begin
    pend_d = (edge_q & (rise | (pend_q & ~(cfg_clr | ack_clr)))) | (~edge_q & src_s);
  end

  always_comb begin
    rdata_d = '0;
    case (bus.cfg_addr)
      A_MASK:  rdata_d = 32'(mask_q);
      A_PEND:  rdata_d = 32'(pend_q);
      A_CAUSE: rdata_d = cause_q;
      A_EDGE:  rdata_d = 32'(edge_q);
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_d_q  <= '0;
      mask_q   <= '0;
      edge_q   <= '1;
      pend_q   <= '0;
      state_q  <= ST_IDLE;
      irq_id_q <= '0;
      ir_out_q <= 1'b0;
      busy_q   <= 1'b0;
      cause_q  <= '0;
      rdata_q  <= '0;
    end else begin
      src_d_q  <= src_d_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
      ir_out_q <= ir_out_d;
      busy_q   <= busy_d;
      cause_q  <= cause_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.ir_out    = ir_out_q;
  assign bus.busy      = busy_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.cfg_rdata = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: vector table for the main flows, hand sequences for reset and latency.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
  localparam int SYNC_PAD = 2;
`else
  localparam int SYNC_PAD = 0;
`endif
  localparam int LAT_IR = SYNC_PAD + 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  irq_controller_if #(.N_SRC(8)) bus ();

  irq_controller #(.N_SRC(8)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  src;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        eret;
    logic        e_ir;
    logic        e_busy;
    logic [4:0]  e_id;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] src, input logic we, input logic [1:0] addr,
                     input logic [31:0] wdata, input logic ack, input logic eret,
                     input logic e_ir, input logic e_busy, input logic [4:0] e_id,
                     input logic [31:0] e_rdata);
    vec_t v;
    v.src = src; v.we = we; v.addr = addr; v.wdata = wdata; v.ack = ack; v.eret = eret;
    v.e_ir = e_ir; v.e_busy = e_busy; v.e_id = e_id; v.e_rdata = e_rdata;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] src, input logic we, input logic [1:0] addr,
                       input logic [31:0] wdata, input logic ack, input logic eret);
    bus.irq_src   = src;
    bus.cfg_we    = we;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = wdata;
    bus.ir_ack    = ack;
    bus.eret      = eret;
  endtask

  initial begin
    logic [7:0] cur_src;
    int n;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(8'h00, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);

    //   src   we addr wdata        ack eret  ir busy id     rdata
    // MASK=0x04, pulse src[2], ack, eret
    add(8'h00, 1, 2'd0, 32'h04,       0, 0,  0, 0, 5'd0, 32'h0);
    add(8'h00, 0, 2'd0, 32'h0,        0, 0,  0, 0, 5'd0, 32'h04);
    add(8'h04, 0, 2'd1, 32'h0,        0, 0,  0, 0, 5'd0, 32'h0);
    add(8'h00, 0, 2'd1, 32'h0,        0, 0,  1, 1, 5'd2, 32'h04);
    add(8'h00, 0, 2'd2, 32'h0,        0, 0,  1, 1, 5'd2, 32'h80000002);
    add(8'h00, 0, 2'd1, 32'h0,        1, 0,  0, 1, 5'd2, 32'h04);
    add(8'h00, 0, 2'd1, 32'h0,        0, 0,  0, 1, 5'd2, 32'h0);
    add(8'h00, 0, 2'd2, 32'h0,        0, 1,  0, 0, 5'd0, 32'h80000002);
    add(8'h00, 0, 2'd2, 32'h0,        0, 0,  0, 0, 5'd0, 32'h0);
    // Priority: pending 5 and 1, MASK=0xFF
    add(8'h00, 1, 2'd0, 32'hFF,       0, 0,  0, 0, 5'd0, 32'h04);
    add(8'h22, 0, 2'd1, 32'h0,        0, 0,  0, 0, 5'd0, 32'h0);
    add(8'h00, 0, 2'd1, 32'h0,        0, 0,  1, 1, 5'd1, 32'h22);
    add(8'h00, 0, 2'd1, 32'h0,        1, 0,  0, 1, 5'd1, 32'h22);
    add(8'h00, 0, 2'd1, 32'h0,        0, 1,  0, 0, 5'd0, 32'h20);
    add(8'h00, 0, 2'd2, 32'h0,        0, 0,  1, 1, 5'd5, 32'h0);
    add(8'h00, 0, 2'd2, 32'h0,        0, 0,  1, 1, 5'd5, 32'h80000005);
    add(8'h00, 0, 2'd2, 32'h0,        1, 0,  0, 1, 5'd5, 32'h80000005);
    add(8'h00, 0, 2'd2, 32'h0,        0, 1,  0, 0, 5'd0, 32'h80000005);
    add(8'h00, 0, 2'd1, 32'h0,        0, 0,  0, 0, 5'd0, 32'h0);
    // Rise and W1C on bit 3 in the same cycle; held edge sets once
    add(8'h00, 1, 2'd0, 32'h0,        0, 0,  0, 0, 5'd0, 32'hFF);
    add(8'h08, 1, 2'd1, 32'h08,       0, 0,  0, 0, 5'd0, 32'h0);
    add(8'h08, 0, 2'd1, 32'h0,        0, 0,  0, 0, 5'd0, 32'h08);
    add(8'h08, 1, 2'd1, 32'h08,       0, 0,  0, 0, 5'd0, 32'h08);
    add(8'h00, 0, 2'd1, 32'h0,        0, 0,  0, 0, 5'd0, 32'h0);
    // MASK cleared in REQ, stray eret in REQ, stray ack in IDLE
    add(8'h00, 1, 2'd0, 32'h01,       0, 0,  0, 0, 5'd0, 32'h0);
    add(8'h01, 0, 2'd1, 32'h0,        0, 0,  0, 0, 5'd0, 32'h0);
    add(8'h00, 0, 2'd0, 32'h0,        0, 0,  1, 1, 5'd0, 32'h01);
    add(8'h00, 1, 2'd0, 32'h0,        0, 0,  1, 1, 5'd0, 32'h01);
    add(8'h00, 0, 2'd0, 32'h0,        0, 1,  1, 1, 5'd0, 32'h0);
    add(8'h00, 0, 2'd0, 32'h0,        0, 0,  1, 1, 5'd0, 32'h0);
    add(8'h00, 0, 2'd0, 32'h0,        1, 0,  0, 1, 5'd0, 32'h0);
    add(8'h00, 0, 2'd0, 32'h0,        0, 1,  0, 0, 5'd0, 32'h0);
    add(8'h01, 0, 2'd1, 32'h0,        0, 0,  0, 0, 5'd0, 32'h0);
    add(8'h00, 0, 2'd1, 32'h0,        1, 0,  0, 0, 5'd0, 32'h01);
    add(8'h00, 0, 2'd1, 32'h0,        0, 0,  0, 0, 5'd0, 32'h01);
    add(8'h00, 1, 2'd1, 32'hFF,       0, 0,  0, 0, 5'd0, 32'h01);
    add(8'h00, 0, 2'd1, 32'h0,        0, 0,  0, 0, 5'd0, 32'h0);
    // Level mode on source 0
    add(8'h00, 1, 2'd3, 32'hFE,       0, 0,  0, 0, 5'd0, 32'hFF);
    add(8'h00, 1, 2'd0, 32'h01,       0, 0,  0, 0, 5'd0, 32'h0);
    add(8'h01, 0, 2'd3, 32'h0,        0, 0,  0, 0, 5'd0, 32'hFE);
    add(8'h01, 0, 2'd1, 32'h0,        0, 0,  1, 1, 5'd0, 32'h01);
    add(8'h01, 0, 2'd1, 32'h0,        1, 0,  0, 1, 5'd0, 32'h01);
    add(8'h01, 0, 2'd1, 32'h0,        0, 1,  0, 0, 5'd0, 32'h01);
    add(8'h01, 0, 2'd1, 32'h0,        0, 0,  1, 1, 5'd0, 32'h01);
    add(8'h01, 0, 2'd1, 32'h0,        1, 0,  0, 1, 5'd0, 32'h01);
    add(8'h00, 0, 2'd1, 32'h0,        0, 0,  0, 1, 5'd0, 32'h01);
    add(8'h00, 0, 2'd1, 32'h0,        0, 1,  0, 0, 5'd0, 32'h0);
    add(8'h00, 0, 2'd1, 32'h0,        0, 0,  0, 0, 5'd0, 32'h0);

    #1;
    chk("rst.ir_out", 32'(bus.ir_out), 32'h0);
    chk("rst.busy",   32'(bus.busy),   32'h0);
    chk("rst.irq_id", 32'(bus.irq_id), 32'h0);
    chk("rst.rdata",  bus.cfg_rdata,   32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cur_src = 8'h00;
    for (int k = 0; k < tbl.size(); k++) begin
      // With the synchroniser, let a changed line reach src_s before the checked cycle.
      if (tbl[k].src != cur_src) begin
        for (int p = 0; p < SYNC_PAD; p++) begin
          @(negedge clk);
          drive(tbl[k].src, 1'b0, tbl[k].addr, 32'h0, 1'b0, 1'b0);
          @(posedge clk);
        end
        cur_src = tbl[k].src;
      end
      @(negedge clk);
      drive(tbl[k].src, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].ack, tbl[k].eret);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.ir_out", k), 32'(bus.ir_out), 32'(tbl[k].e_ir));
      chk($sformatf("v%0d.busy", k),   32'(bus.busy),   32'(tbl[k].e_busy));
      chk($sformatf("v%0d.rdata", k),  bus.cfg_rdata,   tbl[k].e_rdata);
      if (tbl[k].e_busy) chk($sformatf("v%0d.irq_id", k), 32'(bus.irq_id), 32'(tbl[k].e_id));
    end

    // Reset asserted mid-REQ (source 0 still in level mode, MASK=0x01)
    @(negedge clk);
    drive(8'h01, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!bus.ir_out && n < 20);
    chk("prereset.ir_out", 32'(bus.ir_out), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreq_rst.ir_out", 32'(bus.ir_out), 32'h0);
    chk("midreq_rst.busy",   32'(bus.busy),   32'h0);
    chk("midreq_rst.irq_id", 32'(bus.irq_id), 32'h0);
    chk("midreq_rst.rdata",  bus.cfg_rdata,   32'h0);
    drive(8'h00, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      logic [31:0] exp_r;
      exp_r = (a == 3) ? 32'hFF : 32'h0;
      @(negedge clk);
      drive(8'h00, 1'b0, 2'(a), 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("postrst.reg%0d", a), bus.cfg_rdata, exp_r);
    end
    chk("postrst.busy", 32'(bus.busy), 32'h0);

    // Rise-to-ir_out latency on source 7
    @(negedge clk);
    drive(8'h00, 1'b1, 2'd0, 32'h80, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'h80, 1'b0, 2'd2, 32'h0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!bus.ir_out && n < 20);
    chk("lat.posedges", 32'(n), 32'(LAT_IR));
    chk("lat.irq_id",   32'(bus.irq_id), 32'd7);
    @(negedge clk);
    drive(8'h80, 1'b0, 2'd2, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("lat.cause", bus.cfg_rdata, 32'h80000007);
    @(negedge clk);
    drive(8'h00, 1'b0, 2'd1, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive(8'h00, 1'b0, 2'd1, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
    repeat (SYNC_PAD + 3) @(posedge clk);
    #1;
    chk("lat.end_busy",    32'(bus.busy),   32'h0);
    chk("lat.end_ir_out",  32'(bus.ir_out), 32'h0);
    chk("lat.end_pending", bus.cfg_rdata,   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
